// File: rtl/rr_replay_trace_ctrl_pkg.sv
// Shared rr replay package.
// Run-controller state encoding.
package rr_replay_trace_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rr_replay_ctrl_state_t;

endpackage

// File: rtl/rr_replay_trace_ctrl.sv
// Replay run controller: gates trace packets into the decoder.
// Handles start/abort/limit/step, a drain window and run statistics.
module rr_replay_trace_ctrl
  import rr_replay_trace_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 512,
  parameter int LOGB_CHANNEL_CNT = 8,
  parameter int CNT_WIDTH        = 32,
  parameter int DRAIN_CYCLES     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  cfg_step_mode,
  input  logic                  cfg_step,
  input  logic [CNT_WIDTH-1:0]  cfg_pkt_limit,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            st_state,
  output logic                  st_busy,
  output logic                  st_done,
  output logic [CNT_WIDTH-1:0]  st_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  st_logb_cnt,
  output logic [CNT_WIDTH-1:0]  st_stall_cnt
);

  localparam int TW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'(DRAIN_CYCLES - 1);

  rr_replay_ctrl_state_t state_q;
  logic                  credit_q;
  logic [CNT_WIDTH-1:0]  limit_q;
  logic [TW-1:0]         timer_q;
  logic [CNT_WIDTH-1:0]  pkt_q;
  logic [CNT_WIDTH-1:0]  logb_q;
  logic [CNT_WIDTH-1:0]  stall_q;

  logic gate;
  logic fire;
  logic start_ok;
  logic run_clr;
  logic lim_hit;
  logic logb_hit;
  logic stall;

  // Zero-latency gate between buffer and decoder.
  always_comb begin
    gate      = (state_q == ST_RUN) &&
                (!cfg_step_mode || credit_q);
    out_valid = in_valid && gate;
    in_ready  = out_ready && gate;
    out_data  = in_data;
    fire      = out_valid && out_ready;
    start_ok  = cfg_start && !cfg_abort;
    run_clr   = start_ok &&
                (state_q == ST_IDLE ||
                 state_q == ST_DONE);
    lim_hit   = fire && (limit_q != '0) &&
                (pkt_q + 1'b1 == limit_q);
    logb_hit  = |in_data[LOGB_CHANNEL_CNT-1:0];
    stall     = (state_q == ST_RUN) && in_valid &&
                gate && !out_ready;
  end

  // Run FSM with step credit, limit latch and drain timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= 1'b0;
      limit_q  <= '0;
      timer_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q  <= ST_RUN;
            credit_q <= 1'b0;
            limit_q  <= cfg_pkt_limit;
          end
        end
        ST_RUN: begin
          if (cfg_abort || lim_hit) begin
            state_q  <= ST_DRAIN;
            credit_q <= 1'b0;
            timer_q  <= '0;
          end else begin
            credit_q <= cfg_step |
                        (credit_q & ~fire);
          end
        end
        ST_DRAIN: begin
          if (timer_q == TLAST) begin
            state_q <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (start_ok) begin
            state_q  <= ST_RUN;
            credit_q <= 1'b0;
            limit_q  <= cfg_pkt_limit;
          end else if (cfg_abort) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Saturating run statistics, cleared when a run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q   <= '0;
      logb_q  <= '0;
      stall_q <= '0;
    end else if (run_clr) begin
      pkt_q   <= '0;
      logb_q  <= '0;
      stall_q <= '0;
    end else begin
      if (fire && pkt_q != '1)
        pkt_q <= pkt_q + 1'b1;
      if (fire && logb_hit && logb_q != '1)
        logb_q <= logb_q + 1'b1;
      if (stall && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  // Status view of the registered state.
  always_comb begin
    st_state     = state_q;
    st_busy      = (state_q == ST_RUN) ||
                   (state_q == ST_DRAIN);
    st_done      = (state_q == ST_DONE);
    st_pkt_cnt   = pkt_q;
    st_logb_cnt  = logb_q;
    st_stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_rr_replay_trace_ctrl.sv
// Bench for rr_replay_trace_ctrl.
// Directed runs checked against a run-level model each cycle.
module tb_rr_replay_trace_ctrl;

  localparam int DW = 64;
  localparam int LB = 8;
  localparam int CW = 32;
  localparam int DC = 64;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_step_mode = 1'b0;
  logic          cfg_step = 1'b0;
  logic [CW-1:0] cfg_pkt_limit = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [1:0]    st_state;
  logic          st_busy;
  logic          st_done;
  logic [CW-1:0] st_pkt_cnt;
  logic [CW-1:0] st_logb_cnt;
  logic [CW-1:0] st_stall_cnt;

  logic          src_clr = 1'b1;
  logic [55:0]   src_seq;
  logic [7:0]    logb_tab [4];

  int errors = 0;
  int checks = 0;

  rr_replay_trace_ctrl #(
    .DATA_WIDTH      (DW),
    .LOGB_CHANNEL_CNT(LB),
    .CNT_WIDTH       (CW),
    .DRAIN_CYCLES    (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_step_mode(cfg_step_mode),
    .cfg_step     (cfg_step),
    .cfg_pkt_limit(cfg_pkt_limit),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .st_state     (st_state),
    .st_busy      (st_busy),
    .st_done      (st_done),
    .st_pkt_cnt   (st_pkt_cnt),
    .st_logb_cnt  (st_logb_cnt),
    .st_stall_cnt (st_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    logb_tab[0] = 8'h00;
    logb_tab[1] = 8'h04;
    logb_tab[2] = 8'h00;
    logb_tab[3] = 8'h81;
  end

  // Source: sequence number above a logb pattern.
  assign in_data = {src_seq, logb_tab[src_seq[1:0]]};

  always @(posedge clk) begin
    if (src_clr) src_seq <= '0;
    else if (in_valid && in_ready) src_seq <= src_seq + 1;
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Run-level model.
  typedef struct {
    int     st;
    longint pkt;
    longint logb;
    longint stall;
    bit     credit;
    longint limit;
    int     timer;
  } mdl_t;

  mdl_t m;

  function automatic longint sat(longint x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.pkt = 0; r.logb = 0; r.stall = 0;
    r.credit = 0; r.limit = 0; r.timer = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(
    mdl_t c, bit start, bit abort, bit smode, bit step,
    longint lim, bit iv, bit ordy, logic [7:0] lb);
    mdl_t n = c;
    bit open = (c.st == 1) && (!smode || c.credit);
    bit moved = iv && open && ordy;
    if (moved) begin
      n.pkt = sat(c.pkt + 1);
      if (lb != 0) n.logb = sat(c.logb + 1);
    end
    if (c.st == 1 && iv && open && !ordy)
      n.stall = sat(c.stall + 1);
    if (c.st == 1) n.credit = step || (c.credit && !moved);
    if (c.st == 0 || c.st == 3) begin
      if (start && !abort) begin
        n = mreset();
        n.st = 1;
        n.limit = lim;
      end else if (c.st == 3 && abort) begin
        n.st = 0;
      end
    end else if (c.st == 1) begin
      if (abort ||
          (moved && c.limit != 0 && c.pkt + 1 == c.limit)) begin
        n.st = 2;
        n.timer = 0;
        n.credit = 0;
      end
    end else begin
      if (c.timer == DC - 1) n.st = 3;
      else n.timer = c.timer + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else m <= mstep(m, cfg_start, cfg_abort, cfg_step_mode,
                    cfg_step, longint'(cfg_pkt_limit),
                    in_valid, out_ready, in_data[7:0]);
  end

  // Every-cycle comparison against the model.
  bit g_exp;
  always @(negedge clk) begin
    g_exp = (m.st == 1) && (!cfg_step_mode || m.credit);
    chk("state", 64'(st_state), 64'(m.st));
    chk("busy", 64'(st_busy), 64'(m.st == 1 || m.st == 2));
    chk("done", 64'(st_done), 64'(m.st == 3));
    chk("pkt_cnt", 64'(st_pkt_cnt), m.pkt);
    chk("logb_cnt", 64'(st_logb_cnt), m.logb);
    chk("stall_cnt", 64'(st_stall_cnt), m.stall);
    chk("out_valid", 64'(out_valid), 64'(in_valid && g_exp));
    chk("in_ready", 64'(in_ready), 64'(out_ready && g_exp));
    chk("out_data", out_data, in_data);
    if (out_valid && out_ready)
      chk("rx_seq", 64'(out_data[63:8]), m.pkt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(logic [CW-1:0] lim);
    cfg_pkt_limit = lim;
    cfg_start = 1'b1;
    src_clr = 1'b1;
    tick();
    cfg_start = 1'b0;
    src_clr = 1'b0;
  endtask

  task automatic abort_pulse();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic wait_state(logic [1:0] s, int max);
    int n = 0;
    while (st_state !== s && n < max) begin
      tick();
      n++;
    end
    chk("wait_state", 64'(st_state), 64'(s));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_state", 64'(st_state), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(st_busy), 0);
    rst = 1'b0;
    src_clr = 1'b0;
    tick();

    // Packet limit of 5 with a free-running source.
    in_valid = 1'b1;
    out_ready = 1'b1;
    start_run(5);
    repeat (5) tick();
    chk("lim_state", 64'(st_state), 2);
    chk("lim_pkt", 64'(st_pkt_cnt), 5);
    chk("lim_logb", 64'(st_logb_cnt), 2);
    chk("lim_in_ready", 64'(in_ready), 0);
    repeat (63) tick();
    chk("lim_drain_63", 64'(st_state), 2);
    tick();
    chk("lim_done", 64'(st_state), 3);
    chk("lim_done_flag", 64'(st_done), 1);

    // Step mode: three spaced credits, then back-to-back.
    cfg_step_mode = 1'b1;
    start_run(0);
    for (int i = 0; i < 3; i++) begin
      cfg_step = 1'b1;
      tick();
      cfg_step = 1'b0;
      repeat (9) tick();
    end
    chk("step_pkt3", 64'(st_pkt_cnt), 3);
    cfg_step = 1'b1;
    tick();
    tick();
    cfg_step = 1'b0;
    tick();
    tick();
    chk("step_pkt5", 64'(st_pkt_cnt), 5);
    in_valid = 1'b0;
    abort_pulse();
    cfg_step_mode = 1'b0;
    wait_state(3, 80);

    // Backpressure for 7 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1;
    start_run(0);
    repeat (7) tick();
    chk("stall_cnt7", 64'(st_stall_cnt), 7);
    chk("stall_pkt0", 64'(st_pkt_cnt), 0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("stall_pkt3", 64'(st_pkt_cnt), 3);
    chk("stall_hold", 64'(st_stall_cnt), 7);
    in_valid = 1'b0;
    abort_pulse();
    wait_state(3, 80);

    // logb pattern 00,04,00,81.
    in_valid = 1'b1;
    start_run(4);
    repeat (4) tick();
    chk("logb_pkt", 64'(st_pkt_cnt), 4);
    chk("logb_cnt", 64'(st_logb_cnt), 2);
    wait_state(3, 80);

    // Abort after 2 of 10, restart, return to idle.
    start_run(10);
    repeat (2) tick();
    in_valid = 1'b0;
    abort_pulse();
    chk("abort_drain", 64'(st_state), 2);
    wait_state(3, 80);
    chk("abort_pkt", 64'(st_pkt_cnt), 2);
    start_run(0);
    chk("restart_pkt", 64'(st_pkt_cnt), 0);
    chk("restart_state", 64'(st_state), 1);
    abort_pulse();
    wait_state(3, 80);
    abort_pulse();
    chk("done_to_idle", 64'(st_state), 0);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_idle", 64'(st_state), 0);

    // Asynchronous reset mid-run.
    in_valid = 1'b1;
    start_run(0);
    tick();
    #2;
    chk("pre_rst_valid", 64'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_ready", 64'(in_ready), 0);
    chk("arst_state", 64'(st_state), 0);
    chk("arst_busy", 64'(st_busy), 0);
    chk("arst_pkt", 64'(st_pkt_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
